// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// Parity storage is enabled by defining DM_PARITY_EN.
package dm_pkg;

    typedef enum logic [0:0] {
        S_INIT,
        S_IDLE
    } dm_state_e;

    localparam int         DM_BYTES    = 4;
    localparam logic [3:0] DM_WEB_NONE = 4'hF;

    // Even parity: the stored bit makes the 9-bit lane XOR to zero.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// One byte-wide slice of the data SRAM, asynchronous read, synchronous write.
// Defining DM_PARITY_EN adds a parity bit per word and a mismatch output.
module dm_byte_lane
    import dm_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
`ifdef DM_PARITY_EN
    output logic              perr_o,
`endif
    output logic [7:0]        rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

`ifdef DM_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            par_q[addr_i] <= byte_parity(wdata_i);
        end
    end

    assign perr_o = byte_parity(rdata_o) != par_q[addr_i];
`endif

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: byte-lane SRAM with post-reset clear FSM.
// Optional per-byte parity and the dm_perr port appear with DM_PARITY_EN.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W         = 14,
    parameter int          READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] INIT_VALUE     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_OE,
    input  logic [3:0]  DM_WEB,
    input  logic [13:0] DM_addr,
    input  logic [31:0] DM_DI,
`ifdef DM_PARITY_EN
    output logic        dm_perr,
`endif
    output logic [31:0] DM_DO,
    output logic        dm_busy
);

    localparam logic [ADDR_W-1:0] LAST_WORD = '1;
    localparam dm_state_e RST_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;

    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DM_BYTES-1:0] lane_we;
    logic [ADDR_W-1:0]   lane_addr;
    logic [31:0]         lane_wdata;
    logic [31:0]         rd_word;
    logic                unused_addr;

    // Upper address bits alias by truncation.
    assign unused_addr = ^DM_addr;

    assign dm_busy = rst | (state_q == S_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        lane_we    = '0;
        lane_addr  = DM_addr[ADDR_W-1:0];
        lane_wdata = DM_DI;
        unique case (state_q)
            S_INIT: begin
                lane_we    = '1;
                lane_addr  = clr_cnt_q;
                lane_wdata = INIT_VALUE;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                lane_we = ~DM_WEB;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
        if (rst) begin
            lane_we = '0;
        end
    end

`ifdef DM_PARITY_EN
    logic [DM_BYTES-1:0] lane_perr;
`endif

    for (genvar i = 0; i < DM_BYTES; i++) begin : g_lane
        dm_byte_lane #(
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clk    (clk),
            .we_i   (lane_we[i]),
            .addr_i (lane_addr),
            .wdata_i(lane_wdata[8*i +: 8]),
`ifdef DM_PARITY_EN
            .perr_o (lane_perr[i]),
`endif
            .rdata_o(rd_word[8*i +: 8])
        );
    end

    if (READ_LAT != 0) begin : g_reg_rd
        logic [31:0] do_q, do_d;

        // Lanes read asynchronously, so sampling here is read-before-write.
        always_comb begin
            do_d = do_q;
            if (dm_busy) begin
                do_d = '0;
            end else if (DM_OE) begin
                do_d = rd_word;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                do_q <= '0;
            end else begin
                do_q <= do_d;
            end
        end

        assign DM_DO = do_q;

`ifdef DM_PARITY_EN
        logic perr_q, perr_d;

        always_comb begin
            perr_d = 1'b0;
            if (!dm_busy && DM_OE) begin
                perr_d = |lane_perr;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                perr_q <= 1'b0;
            end else begin
                perr_q <= perr_d;
            end
        end

        assign dm_perr = perr_q;
`endif
    end else begin : g_comb_rd
        assign DM_DO = (!dm_busy && DM_OE) ? rd_word : '0;
`ifdef DM_PARITY_EN
        assign dm_perr = !dm_busy && DM_OE && (|lane_perr);
`endif
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (ADDR_W=4, registered read).
// Parity corruption case runs only when DM_PARITY_EN is defined.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        DM_OE;
    logic [3:0]  DM_WEB;
    logic [13:0] DM_addr;
    logic [31:0] DM_DI;
    logic [31:0] DM_DO;
    logic        dm_busy;
`ifdef DM_PARITY_EN
    logic        dm_perr;
`endif

    data_mem_responder #(
        .ADDR_W        (4),
        .READ_LAT      (1),
        .CLEAR_ON_RESET(1'b1),
        .INIT_VALUE    (32'hDEADBEEF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .DM_OE  (DM_OE),
        .DM_WEB (DM_WEB),
        .DM_addr(DM_addr),
        .DM_DI  (DM_DI),
`ifdef DM_PARITY_EN
        .dm_perr(dm_perr),
`endif
        .DM_DO  (DM_DO),
        .dm_busy(dm_busy)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rd_id    = 0;
    logic rd_vld   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // A read accepted at this edge produces DM_DO after it.
    always @(posedge clk) rd_vld <= DM_OE && !dm_busy;

    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: DM_DO=%h with no expected read", DM_DO);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (DM_DO !== e.data) begin
                    failures++;
                    $display("FAIL read#%0d data: got %h expected %h", e.id, DM_DO, e.data);
                end
`ifdef DM_PARITY_EN
                checks++;
                if (dm_perr !== e.perr) begin
                    failures++;
                    $display("FAIL read#%0d perr: got %b expected %b", e.id, dm_perr, e.perr);
                end
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        DM_OE   = 1'b0;
        DM_WEB  = 4'hF;
        DM_addr = '0;
        DM_DI   = '0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] web);
        DM_addr = a;
        DM_DI   = d;
        DM_WEB  = web;
        DM_OE   = 1'b0;
        tick();
        idle_in();
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] d, input logic p);
        exp_t e;
        e.id   = rd_id;
        e.data = d;
        e.perr = p;
        rd_id++;
        sb_q.push_back(e);
        DM_addr = a;
        DM_OE   = 1'b1;
        DM_WEB  = 4'hF;
        tick();
        idle_in();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (dm_busy && n < 100) begin
            chk("do_zero_busy", DM_DO, 32'h0);
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        chk("rst_do", DM_DO, 32'h0);
        chk("rst_busy", {31'b0, dm_busy}, 32'h1);

        // Accesses attempted throughout the clear must be ignored.
        rst     = 1'b0;
        DM_addr = 14'd0;
        DM_DI   = 32'h12345678;
        DM_WEB  = 4'h0;
        DM_OE   = 1'b1;
        count_busy(n);
        idle_in();
        chk("busy_cycles", n, 32'd16);

        for (int a = 0; a < 16; a++) begin
            rd(14'(a), 32'hDEADBEEF, 1'b0);
        end

        wr(14'd5, 32'h11223344, 4'h0);
        wr(14'd5, 32'hAABBCCDD, 4'hA);
        rd(14'd5, 32'h11BB33DD, 1'b0);
        tick();
        chk("hold_1", DM_DO, 32'h11BB33DD);
        tick();
        chk("hold_2", DM_DO, 32'h11BB33DD);

        wr(14'd7, 32'h0, 4'h0);
        DM_addr = 14'd7;
        DM_DI   = 32'h5;
        DM_WEB  = 4'h0;
        DM_OE   = 1'b1;
        sb_q.push_back('{rd_id, 32'h0, 1'b0});
        rd_id++;
        tick();
        idle_in();
        rd(14'd7, 32'h5, 1'b0);

        wr(14'h13, 32'hCAFEF00D, 4'h0);
        rd(14'd3, 32'hCAFEF00D, 1'b0);
        rd(14'h23, 32'hCAFEF00D, 1'b0);
        wr(14'd12, 32'h0BADC0DE, 4'h0);
        rd(14'd12, 32'h0BADC0DE, 1'b0);

        // Abort a clear at word 9 and confirm it restarts from word 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (9) tick();
        chk("busy_mid", {31'b0, dm_busy}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst2_do", DM_DO, 32'h0);
        rst = 1'b0;
        count_busy(n);
        chk("busy_restart", n, 32'd16);
        rd(14'd0, 32'hDEADBEEF, 1'b0);
        rd(14'd3, 32'hDEADBEEF, 1'b0);
        rd(14'd12, 32'hDEADBEEF, 1'b0);
        rd(14'd15, 32'hDEADBEEF, 1'b0);

`ifdef DM_PARITY_EN
        dut.g_lane[2].u_lane.mem_q[2] = 8'hAC;
        rd(14'd2, 32'hDEACBEEF, 1'b1);
        rd(14'd4, 32'hDEADBEEF, 1'b0);
`endif

        tick();
        tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
